// File: rtl/chan_arbiter.sv
// Four-requester arbiter/sequencer for a shared data channel with registered demux slots.
// Optional build macro CHAN_FIXED_PRIORITY_EN selects lowest-index-wins arbitration.
module chan_arbiter #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   src_data,
    input  logic [7:0]            dst_sel,
    output logic [3:0]            gnt,
    output logic [3:0]            done,
    output logic [1:0]            mux_sel,
    output logic [1:0]            demux_sel,
    output logic                  chan_en,
    output logic [4*DATA_W-1:0]   dst_data,
    output logic [3:0]            dst_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StXfer, StGap} stateT;

    localparam logic [7:0] HoldInit = 8'(HOLD_CYCLES - 1);

    stateT               stateQ, stateD;
    logic [7:0]          cntQ, cntD;
    logic [1:0]          lastGrantQ, lastGrantD;
    logic [3:0]          gntQ, gntD;
    logic [3:0]          doneQ, doneD;
    logic [1:0]          muxSelQ, muxSelD;
    logic [1:0]          demuxSelQ, demuxSelD;
    logic                chanEnQ, chanEnD;
    logic [4*DATA_W-1:0] dstDataQ, dstDataD;
    logic [3:0]          dstValidQ, dstValidD;
    logic [1:0]          winner;

`ifdef CHAN_FIXED_PRIORITY_EN
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) winner = 2'(i);
        end
    end
`else
    // Round-robin: scan upward starting just past the previous owner.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = lastGrantQ + 2'(i + 1);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        lastGrantD = lastGrantQ;
        gntD       = gntQ;
        doneD      = 4'b0000;
        muxSelD    = muxSelQ;
        demuxSelD  = demuxSelQ;
        chanEnD    = chanEnQ;
        unique case (stateQ)
            StIdle: begin
                if (|req) begin
                    stateD    = StXfer;
                    gntD      = 4'b0001 << winner;
                    muxSelD   = winner;
                    demuxSelD = dst_sel[{winner, 1'b0} +: 2];
                    chanEnD   = 1'b1;
                    cntD      = HoldInit;
                end
            end
            StXfer: begin
                // A dropped request ends the hold early and forfeits the done pulse.
                if (!req[muxSelQ] || cntQ == 8'd0) begin
                    stateD     = StGap;
                    doneD      = req[muxSelQ] ? gntQ : 4'b0000;
                    gntD       = 4'b0000;
                    chanEnD    = 1'b0;
                    muxSelD    = 2'd0;
                    demuxSelD  = 2'd0;
                    lastGrantD = muxSelQ;
                end else begin
                    cntD = cntQ - 8'd1;
                end
            end
            StGap: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_comb begin
        dstDataD  = '0;
        dstValidD = 4'b0000;
        if (chanEnQ) begin
            dstDataD[demuxSelQ*DATA_W +: DATA_W] = src_data[muxSelQ*DATA_W +: DATA_W];
            dstValidD = 4'b0001 << demuxSelQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= StIdle;
            cntQ       <= 8'd0;
            lastGrantQ <= 2'd3;
            gntQ       <= 4'b0000;
            doneQ      <= 4'b0000;
            muxSelQ    <= 2'd0;
            demuxSelQ  <= 2'd0;
            chanEnQ    <= 1'b0;
            dstDataQ   <= '0;
            dstValidQ  <= 4'b0000;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            lastGrantQ <= lastGrantD;
            gntQ       <= gntD;
            doneQ      <= doneD;
            muxSelQ    <= muxSelD;
            demuxSelQ  <= demuxSelD;
            chanEnQ    <= chanEnD;
            dstDataQ   <= dstDataD;
            dstValidQ  <= dstValidD;
        end
    end

    assign gnt       = gntQ;
    assign done      = doneQ;
    assign mux_sel   = muxSelQ;
    assign demux_sel = demuxSelQ;
    assign chan_en   = chanEnQ;
    assign dst_data  = dstDataQ;
    assign dst_valid = dstValidQ;
    assign busy      = (stateQ != StIdle);

endmodule

// File: tb/tb_chan_arbiter.sv
// Directed bench for chan_arbiter: a HOLD_CYCLES=4 instance and a HOLD_CYCLES=1 instance.
module tb_chan_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  reqA = '0, gntA, doneA, dstValidA;
    logic [15:0] srcA = '0, dstDataA;
    logic [7:0]  dselA = '0;
    logic [1:0]  muxSelA, demuxSelA;
    logic        chanEnA, busyA;

    logic [3:0]  reqB = '0, gntB, doneB, dstValidB;
    logic [15:0] srcB = '0, dstDataB;
    logic [7:0]  dselB = '0;
    logic [1:0]  muxSelB, demuxSelB;
    logic        chanEnB, busyB;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chan_arbiter #(.DATA_W(4), .HOLD_CYCLES(4)) dutA (
        .clk(clk), .rst_n(rst_n), .req(reqA), .src_data(srcA), .dst_sel(dselA),
        .gnt(gntA), .done(doneA), .mux_sel(muxSelA), .demux_sel(demuxSelA),
        .chan_en(chanEnA), .dst_data(dstDataA), .dst_valid(dstValidA), .busy(busyA)
    );

    chan_arbiter #(.DATA_W(4), .HOLD_CYCLES(1)) dutB (
        .clk(clk), .rst_n(rst_n), .req(reqB), .src_data(srcB), .dst_sel(dselB),
        .gnt(gntB), .done(doneB), .mux_sel(muxSelB), .demux_sel(demuxSelB),
        .chan_en(chanEnB), .dst_data(dstDataB), .dst_valid(dstValidB), .busy(busyB)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        chanEn;
        logic        busy;
        logic [3:0]  dstValid;
        logic [15:0] dstData;
        logic [1:0]  muxSel;
        logic [1:0]  demuxSel;
    } vecT;

    vecT vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        reqA  = '0;
        reqB  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst gntA", 32'(gntA), 32'h0);
        check("rst busyA", 32'(busyA), 32'h0);
        check("rst chanEnA", 32'(chanEnA), 32'h0);
        check("rst gntB", 32'(gntB), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int rrWinner(input int k, input int n);
`ifdef CHAN_FIXED_PRIORITY_EN
        return 0;
`else
        return k % n;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        //                req    gnt    done   en  busy valid  data      mux  demux
        vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 1, 1, 4'b0000, 16'h0000, 2'd0, 2'd2};
        vecs[1] = '{4'b0001, 4'b0001, 4'b0000, 1, 1, 4'b0100, 16'h0A00, 2'd0, 2'd2};
        vecs[2] = '{4'b0001, 4'b0001, 4'b0000, 1, 1, 4'b0100, 16'h0A00, 2'd0, 2'd2};
        vecs[3] = '{4'b0001, 4'b0001, 4'b0000, 1, 1, 4'b0100, 16'h0A00, 2'd0, 2'd2};
        vecs[4] = '{4'b0001, 4'b0000, 4'b0001, 0, 1, 4'b0100, 16'h0A00, 2'd0, 2'd0};
        vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 16'h0000, 2'd0, 2'd0};
        vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 16'h0000, 2'd0, 2'd0};

        // Single transfer: requester 0 into slot 2.
        doReset();
        dselA = 8'h02;
        srcA  = 16'h000A;
        for (int i = 0; i < 7; i++) begin
            reqA = vecs[i].req;
            step();
            check($sformatf("v%0d gnt", i), 32'(gntA), 32'(vecs[i].gnt));
            check($sformatf("v%0d done", i), 32'(doneA), 32'(vecs[i].done));
            check($sformatf("v%0d chan_en", i), 32'(chanEnA), 32'(vecs[i].chanEn));
            check($sformatf("v%0d busy", i), 32'(busyA), 32'(vecs[i].busy));
            check($sformatf("v%0d dst_valid", i), 32'(dstValidA), 32'(vecs[i].dstValid));
            check($sformatf("v%0d dst_data", i), 32'(dstDataA), 32'(vecs[i].dstData));
            check($sformatf("v%0d mux_sel", i), 32'(muxSelA), 32'(vecs[i].muxSel));
            check($sformatf("v%0d demux_sel", i), 32'(demuxSelA), 32'(vecs[i].demuxSel));
        end

        // All four requesting for 12 transfers; period HOLD_CYCLES+2 = 6.
        doReset();
        dselA = 8'hE4;
        srcA  = 16'h4321;
        reqA  = 4'hF;
        for (int e = 1; e <= 72; e++) begin
            int p, k, w;
            logic [3:0] expG, expD;
            step();
            p = (e - 1) % 6;
            k = (e - 1) / 6;
            w = rrWinner(k, 4);
            expG = (p < 4) ? 4'(1 << w) : 4'b0000;
            expD = (p == 4) ? 4'(1 << w) : 4'b0000;
            check($sformatf("rr%0d gnt", e), 32'(gntA), 32'(expG));
            check($sformatf("rr%0d done", e), 32'(doneA), 32'(expD));
            if (p == 1) begin
                check($sformatf("rr%0d dst_valid", e), 32'(dstValidA), 32'(1 << w));
                check($sformatf("rr%0d dst_data", e), 32'(dstDataA),
                      32'(16'h4321 & (16'hF << (4 * w))));
            end
        end

        // Abort: requester 2 drops in its second XFER cycle.
        doReset();
        dselA = 8'h00;
        reqA  = 4'b0100;
        step();
        check("ab gnt1", 32'(gntA), 32'h4);
        step();
        check("ab gnt2", 32'(gntA), 32'h4);
        reqA = 4'b0000;
        step();
        check("ab gap gnt", 32'(gntA), 32'h0);
        check("ab gap done", 32'(doneA), 32'h0);
        check("ab gap busy", 32'(busyA), 32'h1);
        reqA = 4'b1011;
        step();
        check("ab idle busy", 32'(busyA), 32'h0);
        check("ab idle done", 32'(doneA), 32'h0);
        step();
`ifdef CHAN_FIXED_PRIORITY_EN
        check("ab next gnt", 32'(gntA), 32'h1);
`else
        check("ab next gnt", 32'(gntA), 32'h8);
`endif

        // Reset asserted mid-XFER clears everything immediately.
        doReset();
        dselA = 8'h03;
        srcA  = 16'h0007;
        reqA  = 4'b0001;
        step();
        step();
        check("mr gnt pre", 32'(gntA), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mr gnt", 32'(gntA), 32'h0);
        check("mr done", 32'(doneA), 32'h0);
        check("mr chan_en", 32'(chanEnA), 32'h0);
        check("mr busy", 32'(busyA), 32'h0);
        check("mr dst_valid", 32'(dstValidA), 32'h0);
        check("mr dst_data", 32'(dstDataA), 32'h0);
        check("mr demux_sel", 32'(demuxSelA), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        reqA  = 4'b1000;
        step();
        check("mr regrant gnt", 32'(gntA), 32'h8);
        check("mr regrant mux", 32'(muxSelA), 32'h3);
        check("mr regrant busy", 32'(busyA), 32'h1);

        // HOLD_CYCLES=1: req 0 -> slot 1 (data 5), req 1 -> slot 3 (data C); period 3.
        doReset();
        dselB = 8'b0000_1101;
        srcB  = 16'h00C5;
        reqB  = 4'b0011;
        for (int e = 1; e <= 12; e++) begin
            int p, k, w, slot;
            logic [3:0]  expG, expD, expV;
            logic [15:0] expData;
            step();
            p    = (e - 1) % 3;
            k    = (e - 1) / 3;
            w    = rrWinner(k, 2);
            slot = (w == 0) ? 1 : 3;
            expG    = (p == 0) ? 4'(1 << w) : 4'b0000;
            expD    = (p == 1) ? 4'(1 << w) : 4'b0000;
            expV    = (p == 1) ? 4'(1 << slot) : 4'b0000;
            expData = (p == 1) ? 16'(((w == 0) ? 5 : 12) << (4 * slot)) : 16'h0000;
            check($sformatf("h1_%0d gnt", e), 32'(gntB), 32'(expG));
            check($sformatf("h1_%0d done", e), 32'(doneB), 32'(expD));
            check($sformatf("h1_%0d dst_valid", e), 32'(dstValidB), 32'(expV));
            check($sformatf("h1_%0d dst_data", e), 32'(dstDataB), 32'(expData));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
